// File: rtl/dcache_wb_buffer_pkg.sv
// Shared types for the Dcache write-back (victim) buffer.
// Provides the memory bus command encoding, the cache address layout,
// the buffer entry record and the drain FSM state type.
package dcache_wb_buffer_pkg;

  // Default number of buffered victim lines (power of two, >= 2).
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  // 64-bit cache address view: 8-byte lines, 8 sets. Only tag+set_index
  // identify a line; the ignore field is always zero for victims.
  typedef struct packed {
    logic [31:0] ignore;
    logic [25:0] tag;
    logic [2:0]  set_index;
    logic [2:0]  block_offset;
  } SASS_ADDR;

  typedef struct packed {
    logic        valid;
    SASS_ADDR    addr;
    logic [63:0] data;
  } WB_ENTRY_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } WB_STATE_t;

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Memory-arbiter side of the write-back buffer.
//   mem_grant          arbiter gives the bus to the buffer this cycle
//   mem2proc_response  memory tag, nonzero = store accepted
//   proc2mem_command   BUS_STORE while requesting and granted
//   proc2mem_addr/data head entry being drained
// master = write-back buffer, slave = arbiter/memory.
interface dcache_wb_buffer_if;
  import dcache_wb_buffer_pkg::*;

  logic        mem_grant;
  logic [3:0]  mem2proc_response;
  BUS_COMMAND  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;

  modport master (
    input  mem_grant, mem2proc_response,
    output proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport slave (
    output mem_grant, mem2proc_response,
    input  proc2mem_command, proc2mem_addr, proc2mem_data
  );
endinterface

// File: rtl/dcache_wb_buffer_wb_addr_cam.sv
// Address CAM over the write-back buffer entries.
//   entries       buffered lines (valid/addr/data)
//   rd_addr       lookup address, compared on tag+set_index
//   tail          next allocation slot; tail-1 is the youngest entry
//   match         per-entry hit vector
//   youngest_idx  index of the matching entry closest to tail
//   hit           any entry matched
module dcache_wb_buffer_wb_addr_cam
  import dcache_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT,
  parameter int WB_IDX_W = $clog2(WB_DEPTH)
) (
  input  WB_ENTRY_t           entries [WB_DEPTH],
  input  SASS_ADDR            rd_addr,
  input  logic [WB_IDX_W-1:0] tail,
  output logic [WB_DEPTH-1:0] match,
  output logic [WB_IDX_W-1:0] youngest_idx,
  output logic                hit
);

  logic [WB_DEPTH-1:0] unused_entry_bits;
  logic                unused_rd_bits;
  logic [WB_IDX_W-1:0] idx;

  genvar gi;
  generate
    for (gi = 0; gi < WB_DEPTH; gi++) begin : g_match
      assign match[gi] = entries[gi].valid &&
                         (entries[gi].addr.tag == rd_addr.tag) &&
                         (entries[gi].addr.set_index == rd_addr.set_index);
      assign unused_entry_bits[gi] = ^{entries[gi].data, entries[gi].addr.ignore,
                                       entries[gi].addr.block_offset};
    end
  endgenerate

  assign unused_rd_bits = ^{rd_addr.ignore, rd_addr.block_offset};
  assign hit = |match;

  // Walk from oldest (tail-DEPTH, which is tail itself) to youngest
  // (tail-1); the last hit seen wins, so the youngest match is chosen.
  always_comb begin
    youngest_idx = '0;
    idx          = '0;
    for (int k = WB_DEPTH; k >= 1; k--) begin
      idx = tail - WB_IDX_W'(k);
      if (match[idx]) youngest_idx = idx;
    end
  end

endmodule

// File: rtl/dcache_wb_buffer.sv
// Write-back (victim) buffer between Dcache evictions and memory.
// Dirty victims are queued FIFO and drained one at a time as BUS_STORE
// requests; loads can hit buffered lines so a just-evicted line is not lost.
//   clock, reset        clock and synchronous active-high reset
//   evict_en/evicted_*  victim line offered by a Dcache fill
//   rd_addr/rd_hit/rd_data  combinational load-path lookup
//   mem                 arbiter/memory bus (master modport)
//   wb_full/wb_empty    decoded from the registered occupancy count
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT,
  parameter int WB_IDX_W = $clog2(WB_DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      evict_en,
  input  logic                      evicted_valid_in,
  input  logic                      evicted_dirty_in,
  input  SASS_ADDR                  evicted_addr_in,
  input  logic [63:0]               evicted_data_in,
  input  SASS_ADDR                  rd_addr,
  output logic                      rd_hit,
  output logic [63:0]               rd_data,
  dcache_wb_buffer_if.master        mem,
  output logic                      wb_full,
  output logic                      wb_empty
);

  WB_ENTRY_t           entries_reg [WB_DEPTH];
  WB_ENTRY_t           coal_view   [WB_DEPTH];
  logic [WB_IDX_W-1:0] head_reg, tail_reg;
  logic [WB_IDX_W:0]   count_reg, count_next;
  WB_STATE_t           state_reg, state_next;

  logic                push, alloc, coalesce, accept;
  logic [WB_DEPTH-1:0] unused_rd_match, unused_coal_match;
  logic [WB_IDX_W-1:0] rd_idx, coal_idx;
  logic                coal_hit;

  assign push     = evict_en & evicted_valid_in & evicted_dirty_in;
  assign wb_full  = (count_reg == (WB_IDX_W+1)'(WB_DEPTH));
  assign wb_empty = (count_reg == '0);
  assign accept   = (state_reg == WB_REQ) && mem.mem_grant &&
                    (mem.mem2proc_response != 4'd0);

  // The head is being offered to memory while in WB_REQ, so it is hidden
  // from coalescing; a matching victim then gets a fresh slot instead.
  genvar gi;
  generate
    for (gi = 0; gi < WB_DEPTH; gi++) begin : g_coal_view
      assign coal_view[gi] = '{
        valid: entries_reg[gi].valid &&
               !((state_reg == WB_REQ) && (head_reg == WB_IDX_W'(gi))),
        addr:  entries_reg[gi].addr,
        data:  entries_reg[gi].data
      };
    end
  endgenerate

  dcache_wb_buffer_wb_addr_cam #(.WB_DEPTH(WB_DEPTH), .WB_IDX_W(WB_IDX_W)) u_rd_cam (
    .entries      (entries_reg),
    .rd_addr      (rd_addr),
    .tail         (tail_reg),
    .match        (unused_rd_match),
    .youngest_idx (rd_idx),
    .hit          (rd_hit)
  );

  dcache_wb_buffer_wb_addr_cam #(.WB_DEPTH(WB_DEPTH), .WB_IDX_W(WB_IDX_W)) u_coal_cam (
    .entries      (coal_view),
    .rd_addr      (evicted_addr_in),
    .tail         (tail_reg),
    .match        (unused_coal_match),
    .youngest_idx (coal_idx),
    .hit          (coal_hit)
  );

  // A push while full is dropped outright, including any coalesce.
  assign coalesce = push && !wb_full && coal_hit;
  assign alloc    = push && !wb_full && !coal_hit;

  always_comb begin
    count_next = count_reg;
    if (alloc && !accept)      count_next = count_reg + (WB_IDX_W+1)'(1);
    else if (!alloc && accept) count_next = count_reg - (WB_IDX_W+1)'(1);
  end

  assign state_next = (count_next != '0) ? WB_REQ : WB_IDLE;

  assign rd_data              = rd_hit ? entries_reg[rd_idx].data : 64'd0;
  assign mem.proc2mem_command = ((state_reg == WB_REQ) && mem.mem_grant) ? BUS_STORE : BUS_NONE;
  assign mem.proc2mem_addr    = (state_reg == WB_REQ) ? entries_reg[head_reg].addr : 64'd0;
  assign mem.proc2mem_data    = (state_reg == WB_REQ) ? entries_reg[head_reg].data : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WB_DEPTH; i++) entries_reg[i] <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= WB_IDLE;
    end else begin
      assert (!(push && wb_full))
        else $warning("dcache_wb_buffer: victim pushed while full was dropped");
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        entries_reg[head_reg].valid <= 1'b0;
        head_reg <= head_reg + WB_IDX_W'(1);
      end
      if (alloc) begin
        entries_reg[tail_reg] <= '{valid: 1'b1, addr: evicted_addr_in, data: evicted_data_in};
        tail_reg <= tail_reg + WB_IDX_W'(1);
      end
      if (coalesce) entries_reg[coal_idx].data <= evicted_data_in;
    end
  end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
module tb_dcache_wb_buffer;
  import dcache_wb_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        evict_en, evicted_valid_in, evicted_dirty_in;
  SASS_ADDR    evicted_addr_in, rd_addr;
  logic [63:0] evicted_data_in;
  logic        rd_hit, wb_full, wb_empty;
  logic [63:0] rd_data;

  int checks = 0;
  int errors = 0;

  dcache_wb_buffer_if bus();

  dcache_wb_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .evict_en         (evict_en),
    .evicted_valid_in (evicted_valid_in),
    .evicted_dirty_in (evicted_dirty_in),
    .evicted_addr_in  (evicted_addr_in),
    .evicted_data_in  (evicted_data_in),
    .rd_addr          (rd_addr),
    .rd_hit           (rd_hit),
    .rd_data          (rd_data),
    .mem              (bus),
    .wb_full          (wb_full),
    .wb_empty         (wb_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en, valid, dirty;
    logic [63:0] ev_addr, ev_data, rd;
    logic        grant;
    logic [3:0]  resp;
    BUS_COMMAND  cmd;
    logic [63:0] addr, data;
    logic        hit;
    logic [63:0] rdd;
    logic        full, empty;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } mentry_t;

  vec_t    vecs[7];
  mentry_t q[$];

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic valid, logic dirty, logic [63:0] a, logic [63:0] d,
                       logic [63:0] rda, logic g, logic [3:0] r);
    evict_en = en; evicted_valid_in = valid; evicted_dirty_in = dirty;
    evicted_addr_in = a; evicted_data_in = d; rd_addr = rda;
    bus.mem_grant = g; bus.mem2proc_response = r;
  endtask

  // Waits to the falling edge, then compares all observable outputs.
  task automatic expect_out(string tag, BUS_COMMAND cmd, logic [63:0] a, logic [63:0] d,
                            logic hit, logic [63:0] rdd, logic full, logic empty);
    @(negedge clock);
    check64($sformatf("%s.cmd", tag), 64'(bus.proc2mem_command), 64'(cmd));
    if (cmd == BUS_STORE) begin
      check64($sformatf("%s.addr", tag), bus.proc2mem_addr, a);
      check64($sformatf("%s.data", tag), bus.proc2mem_data, d);
    end
    check64($sformatf("%s.hit", tag), 64'(rd_hit), 64'(hit));
    check64($sformatf("%s.rd_data", tag), rd_data, rdd);
    check64($sformatf("%s.full", tag), 64'(wb_full), 64'(full));
    check64($sformatf("%s.empty", tag), 64'(wb_empty), 64'(empty));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [28:0] line_key(logic [63:0] a);
    return a[31:3];
  endfunction

  initial begin
    logic [63:0] a, d, rda, exp_a, exp_d, exp_rdd;
    logic        en, v, dty, g, exp_hit, acc, found;
    logic [3:0]  r;
    BUS_COMMAND  exp_cmd;

    // Single-cycle vectors: one store with two retries, then a clean victim.
    vecs[0] = '{1'b1,1'b1,1'b1,64'h100,64'hAAAA,64'h100,1'b1,4'd0,BUS_NONE, 64'h0,  64'h0,   1'b0,64'h0,   1'b0,1'b1};
    vecs[1] = '{1'b0,1'b0,1'b0,64'h0,  64'h0,   64'h100,1'b1,4'd0,BUS_STORE,64'h100,64'hAAAA,1'b1,64'hAAAA,1'b0,1'b0};
    vecs[2] = '{1'b0,1'b0,1'b0,64'h0,  64'h0,   64'h100,1'b1,4'd0,BUS_STORE,64'h100,64'hAAAA,1'b1,64'hAAAA,1'b0,1'b0};
    vecs[3] = '{1'b0,1'b0,1'b0,64'h0,  64'h0,   64'h100,1'b1,4'd3,BUS_STORE,64'h100,64'hAAAA,1'b1,64'hAAAA,1'b0,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b0,64'h0,  64'h0,   64'h100,1'b0,4'd0,BUS_NONE, 64'h0,  64'h0,   1'b0,64'h0,   1'b0,1'b1};
    vecs[5] = '{1'b1,1'b1,1'b0,64'h200,64'hBBBB,64'h200,1'b1,4'd1,BUS_NONE, 64'h0,  64'h0,   1'b0,64'h0,   1'b0,1'b1};
    vecs[6] = '{1'b0,1'b0,1'b0,64'h0,  64'h0,   64'h200,1'b1,4'd1,BUS_NONE, 64'h0,  64'h0,   1'b0,64'h0,   1'b0,1'b1};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;

    // Reset state, including zeroed bus address/data.
    drive(0, 0, 0, 0, 0, 64'h100, 1, 4'd1);
    @(negedge clock);
    check64("reset.addr", bus.proc2mem_addr, 64'h0);
    check64("reset.data", bus.proc2mem_data, 64'h0);
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("idle%0d", i), BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].dirty, vecs[i].ev_addr, vecs[i].ev_data,
            vecs[i].rd, vecs[i].grant, vecs[i].resp);
      expect_out($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].data,
                 vecs[i].hit, vecs[i].rdd, vecs[i].full, vecs[i].empty);
      $display("vec %0d applied", i);
      tick();
    end

    // Coalesce into a non-head entry, then drain in order.
    drive(1, 1, 1, 64'h100, 64'h1, 64'h140, 0, 0);
    expect_out("co0", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1); tick();
    drive(1, 1, 1, 64'h140, 64'h2, 64'h140, 0, 0);
    expect_out("co1", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b0); tick();
    drive(1, 1, 1, 64'h140, 64'h3, 64'h140, 0, 0);
    expect_out("co2", BUS_NONE, 0, 0, 1'b1, 64'h2, 1'b0, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 64'h140, 0, 0);
    expect_out("co3", BUS_NONE, 0, 0, 1'b1, 64'h3, 1'b0, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 64'h100, 1, 4'd1);
    expect_out("co4", BUS_STORE, 64'h100, 64'h1, 1'b1, 64'h1, 1'b0, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 64'h100, 1, 4'd1);
    expect_out("co5", BUS_STORE, 64'h140, 64'h3, 1'b0, 64'h0, 1'b0, 1'b0); tick();
    expect_out("co6", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1); tick();
    $display("coalesce sequence done");

    // Fill to full, drop a fifth victim, drain across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 64'h1000 + 64'(i) * 64'h40, 64'hD0 + 64'(i), 64'h1100, 0, 0);
      expect_out($sformatf("fill%0d", i), BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, (i == 0));
      tick();
    end
    drive(1, 1, 1, 64'h1100, 64'hEE, 64'h1100, 0, 0);
    expect_out("full", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b1, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 64'h1100, 0, 0);
    expect_out("dropped", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 64'h1100, 1, 4'd1);
      expect_out($sformatf("wrap%0d", i), BUS_STORE, 64'h1000 + 64'(i) * 64'h40,
                 64'hD0 + 64'(i), 1'b0, 64'h0, (i == 0), 1'b0);
      $display("wrap store %0d", i);
      tick();
    end
    expect_out("wrapdone", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1); tick();

    // Randomized traffic against a queue model of the buffer.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      en  = (q.size() < 4) && ($urandom_range(0, 2) != 0);
      v   = ($urandom_range(0, 9) != 0);
      dty = ($urandom_range(0, 4) != 0);
      a   = 64'h2000 + 64'($urandom_range(0, 5)) * 8 + 64'($urandom_range(0, 7));
      d   = {32'($urandom), 32'($urandom)};
      rda = 64'h2000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
      g   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      drive(en, v, dty, a, d, rda, g, r);

      exp_cmd = (q.size() != 0 && g) ? BUS_STORE : BUS_NONE;
      exp_a = 0; exp_d = 0;
      if (q.size() != 0) begin exp_a = q[0].addr; exp_d = q[0].data; end
      exp_hit = 1'b0; exp_rdd = 64'h0;
      foreach (q[i]) if (line_key(q[i].addr) == line_key(rda)) begin
        exp_hit = 1'b1; exp_rdd = q[i].data;
      end
      expect_out($sformatf("rnd%0d", c), exp_cmd, exp_a, exp_d, exp_hit, exp_rdd,
                 (q.size() == 4), (q.size() == 0));

      acc = (q.size() != 0) && g && (r != 0);
      if (acc) $display("rnd store %h %h", exp_a, exp_d);
      if (en && v && dty && q.size() < 4) begin
        found = 1'b0;
        for (int i = q.size() - 1; i >= 1; i--)
          if (!found && line_key(q[i].addr) == line_key(a)) begin
            q[i].data = d; found = 1'b1;
          end
        if (!found) q.push_back('{addr: a, data: d});
      end
      if (acc) void'(q.pop_front());
      tick();
    end

    // Reset while requesting abandons the store and empties the buffer.
    reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); reset = 1'b0;
    drive(1, 1, 1, 64'h3000, 64'h11, 64'h3000, 0, 0); tick();
    drive(1, 1, 1, 64'h3040, 64'h22, 64'h3000, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 64'h3040, 1, 4'd0);
    expect_out("prerst", BUS_STORE, 64'h3000, 64'h11, 1'b1, 64'h22, 1'b0, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 0, 0, 0, 0, 64'h3000, 1, 4'd1);
    expect_out("rst0", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1); tick();
    drive(0, 0, 0, 0, 0, 64'h3040, 1, 4'd1);
    expect_out("rst1", BUS_NONE, 0, 0, 1'b0, 64'h0, 1'b0, 1'b1); tick();
    $display("reset sequence done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
- Write-back (victim) buffer directly downstream of the Dcache eviction outputs.
- Captures dirty lines evicted when a memory fill overwrites the LRU way, and queues them in FIFO order.
- Drains them to memory as BUS_STORE requests, one at a time, through the memory arbiter.
- Forwards buffered data to the load path so a load to a just-evicted line is not lost. Its drained state is part of the halt condition.

Parameters:
- WB_DEPTH, 4, number of buffered lines (power of two, ≥2).
- WB_IDX_W, $clog2(WB_DEPTH), head/tail pointer width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- evict_en  in  1  Dcache fill this cycle (wr1_en & wr1_from_mem)
- evicted_valid_in  in  1  victim line valid
- evicted_dirty_in  in  1  victim line dirty
- evicted_addr_in  in  SASS_ADDR  victim address (ignore field = 0)
- evicted_data_in  in  64  victim data
- rd_addr  in  SASS_ADDR  load lookup address
- rd_hit  out  1  lookup matches a buffered line
- rd_data  out  64  data of youngest matching entry
- mem_grant  in  1  arbiter grants the memory bus to this block this cycle
- mem2proc_response  in  4  memory tag; nonzero means request accepted
- proc2mem_command  out  BUS_COMMAND  BUS_STORE while requesting, else BUS_NONE
- proc2mem_addr  out  64  head entry address
- proc2mem_data  out  64  head entry data
- wb_full  out  1  count == WB_DEPTH; Dcache must stall fills
- wb_empty  out  1  count == 0; used in halt/drain condition

Behaviour:
- Reset (synchronous):
  - all entries invalid; head = tail = count = 0; state WB_IDLE.
  - Outputs: proc2mem_command = BUS_NONE, proc2mem_addr = 0, proc2mem_data = 0, rd_hit = 0, rd_data = 0, wb_full = 0, wb_empty = 1.
  - Reset mid-request abandons the store with no retry.
- Push condition: evict_en & evicted_valid_in & evicted_dirty_in. Clean or invalid victims are ignored.
- Coalesce: if a valid non-head entry matches on tag+set_index, overwrite its data in place; count unchanged. The head entry is never coalesced while in WB_REQ; a new entry is allocated instead.
- Allocate: if no coalesce and !wb_full, write at tail, tail <= tail+1 (wraps modulo WB_DEPTH), count+1.
- Push while wb_full: dropped. This is a protocol violation; an assertion fires in simulation.
- wb_full and wb_empty are decoded from registered count, so they are valid the cycle after the update.
- FSM:
  - WB_IDLE: proc2mem_command = BUS_NONE. Goes to WB_REQ next cycle if count != 0 (includes a push this cycle).
  - WB_REQ: drives BUS_STORE with head addr/data, combinationally gated by mem_grant (BUS_NONE when not granted).
  - Accept = mem_grant & (mem2proc_response != 0). On accept: head entry invalidated, head <= head+1, count-1. Stays in WB_REQ if the remaining count (after any same-cycle push) != 0, else goes to WB_IDLE.
  - Grant without a nonzero response: hold head, retry next cycle.
- Simultaneous push and accept: both take effect; count unchanged. When wb_full, a push in the same cycle as an accept is still refused, because full is registered.
- Lookup (combinational, same cycle):
  - Compares rd_addr tag+set_index against all valid entries.
  - rd_hit = any match; rd_data = youngest match (closest to tail), else 0.
  - An entry being pushed this cycle is not visible until the next cycle.
  - An entry being accepted this cycle is still visible this cycle.
- Latency: a victim pushed at cycle N can appear on the bus at N+1 at the earliest.

Decomposition:
- Shared package / sys_defs:
  - WB_ENTRY_t {valid, SASS_ADDR addr, [63:0] data}
  - WB_STATE_t enum {WB_IDLE, WB_REQ}
  - `WB_DEPTH define
  - existing BUS_COMMAND and SASS_ADDR
- One natural sub-module: wb_addr_cam. It takes entries + rd_addr + head/tail and returns match vector, youngest-match index and hit, so the priority logic is tested alone.

Test Plan:
- Reset, then idle 5 cycles -> wb_empty = 1, proc2mem_command = BUS_NONE, rd_hit = 0 every cycle.
- Push dirty victim addr 0x100, data 0xAAAA; mem_grant = 1, response 0 for 2 cycles then 3 -> BUS_STORE 0x100/0xAAAA held 3 cycles, pop on the third, wb_empty = 1 next cycle.
- Push clean victim 0x200 -> count stays 0, no bus activity.
- Push 0x100 (0x1), 0x140 (0x2), then 0x140 (0x3) with no grant -> count = 2; rd_addr = 0x140 gives rd_hit = 1, rd_data = 0x3; stores drain in order 0x100, then 0x140/0x3.
- Fill 4 entries without grant -> wb_full = 1. A fifth push is dropped and the assertion fires. Grant with response 1 for 4 cycles -> FIFO order preserved across pointer wrap.
- Assert reset while in WB_REQ with 2 entries -> next cycle BUS_NONE, wb_empty = 1, rd_hit = 0 for the previously buffered addresses.
